// File: rtl/status_register_unit_pkg.sv
// Shared constants for the NZCV status unit: condition codes, flag bit positions, status width.
// Status word packing is {Z,C,N,V} with Z in the MSB.
package status_register_unit_pkg;

    localparam int STATUS_W = 4;

    localparam int Z_BIT = 3;
    localparam int C_BIT = 2;
    localparam int N_BIT = 1;
    localparam int V_BIT = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_CS = 4'd2,
        COND_CC = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14
    } cond_e;

    typedef struct packed {
        logic z;
        logic c;
        logic n;
        logic v;
    } flags_t;

    // Unpacks a raw ALU flag word by named bit position.
    function automatic flags_t to_flags(input logic [STATUS_W-1:0] w);
        flags_t f;
        f.z = w[Z_BIT];
        f.c = w[C_BIT];
        f.n = w[N_BIT];
        f.v = w[V_BIT];
        return f;
    endfunction

endpackage

// File: rtl/status_register_unit_sat_counter.sv
// Saturating up-counter with async active-low clear; stops at all-ones.
// Latency: count visible one cycle after i_inc; no backpressure (i_inc is a plain enable).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;
    logic         w_sat;

    assign w_sat = &r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_inc && !w_sat) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/status_register_unit.sv
// Architectural NZCV register feeding condition check; forwards EXE flags or stalls ID on a flag dependency.
// Latency: status_reg one cycle after the EXE write, status_to_cond same cycle when forwarding; freeze holds all state.
module status_register_unit
    import status_register_unit_pkg::*;
#(
    parameter bit FORWARD_EN = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                flush,
    input  logic                ex_valid,
    input  logic                ex_s,
    input  logic                ex_cond_pass,
    input  logic [STATUS_W-1:0] alu_flags,
    input  logic                id_valid,
    input  logic [3:0]          id_cond,
    output logic [STATUS_W-1:0] status_reg,
    output logic [STATUS_W-1:0] status_to_cond,
    output logic                flags_hazard,
    output logic [CNT_W-1:0]    update_count
);

    flags_t r_flags;
    logic   w_ex_sets;
    logic   w_wr;
    logic   w_dep;

    // An S instruction that really commits its flags this cycle, ignoring freeze.
    assign w_ex_sets = ex_valid & ex_s & ex_cond_pass & ~flush;
    assign w_wr      = w_ex_sets & ~freeze;

    // Freeze is deliberately left out: a held pipeline keeps presenting the same pair.
    assign w_dep = w_ex_sets & id_valid & (id_cond != COND_AL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flags <= '0;
        end else if (w_wr) begin
            r_flags <= to_flags(alu_flags);
        end
    end

    assign status_reg = r_flags;

    sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_inc   (w_wr),
        .o_count (update_count)
    );

    generate
        if (FORWARD_EN) begin : g_fwd
            assign status_to_cond = w_dep ? alu_flags : status_reg;
            assign flags_hazard   = 1'b0;
        end else begin : g_stall
            assign status_to_cond = status_reg;
            assign flags_hazard   = w_dep;
        end
    endgenerate

endmodule

// File: tb/tb_status_register_unit.sv
// Randomised bench for status_register_unit: a forwarding instance and a stalling, narrow-counter instance share stimulus.
module tb_status_register_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       freeze = 1'b0, flush = 1'b0;
    logic       ex_valid = 1'b0, ex_s = 1'b0, ex_cond_pass = 1'b0;
    logic [3:0] alu_flags = 4'h0;
    logic       id_valid = 1'b0;
    logic [3:0] id_cond = 4'h0;

    logic [3:0]  f_sr, f_stc, s_sr, s_stc;
    logic        f_hz, s_hz;
    logic [15:0] f_cnt;
    logic [3:0]  s_cnt;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    logic [3:0] m_st;
    int         m_cf;
    int         m_cs;

    always #5 clk = ~clk;

    status_register_unit #(.FORWARD_EN(1'b1), .CNT_W(16)) u_fwd (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .ex_valid(ex_valid), .ex_s(ex_s), .ex_cond_pass(ex_cond_pass),
        .alu_flags(alu_flags), .id_valid(id_valid), .id_cond(id_cond),
        .status_reg(f_sr), .status_to_cond(f_stc), .flags_hazard(f_hz),
        .update_count(f_cnt)
    );

    status_register_unit #(.FORWARD_EN(1'b0), .CNT_W(4)) u_stl (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .ex_valid(ex_valid), .ex_s(ex_s), .ex_cond_pass(ex_cond_pass),
        .alu_flags(alu_flags), .id_valid(id_valid), .id_cond(id_cond),
        .status_reg(s_sr), .status_to_cond(s_stc), .flags_hazard(s_hz),
        .update_count(s_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit wr_now();
        return ex_valid && ex_s && ex_cond_pass && !flush && !freeze;
    endfunction

    function automatic bit dep_now();
        return ex_valid && ex_s && ex_cond_pass && !flush && id_valid && (id_cond != 4'd14);
    endfunction

    // Reference model: architectural flags plus two saturating write tallies.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_st <= 4'h0;
            m_cf <= 0;
            m_cs <= 0;
        end else if (wr_now()) begin
            m_st <= alu_flags;
            m_cf <= (m_cf < 65535) ? m_cf + 1 : m_cf;
            m_cs <= (m_cs < 15) ? m_cs + 1 : m_cs;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("fwd_status_reg", f_sr, m_st);
            chk("fwd_to_cond", f_stc, dep_now() ? alu_flags : m_st);
            chk("fwd_hazard", f_hz, 0);
            chk("fwd_count", f_cnt, m_cf);
            chk("stl_status_reg", s_sr, m_st);
            chk("stl_to_cond", s_stc, m_st);
            chk("stl_hazard", s_hz, dep_now());
            chk("stl_count", s_cnt, m_cs);
        end
    end

    task automatic drv(input logic v, input logic s, input logic cp, input logic fl,
                       input logic fr, input logic [3:0] a, input logic iv, input logic [3:0] ic);
        ex_valid     = v;
        ex_s         = s;
        ex_cond_pass = cp;
        flush        = fl;
        freeze       = fr;
        alu_flags    = a;
        id_valid     = iv;
        id_cond      = ic;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] last;
        drv(0, 0, 0, 0, 0, 4'h0, 0, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b1;
        cmp_en = 1'b1;
        chk("reset_sr", f_sr, 4'h0);
        chk("reset_cnt", f_cnt, 0);
        chk("reset_stl_cnt", s_cnt, 0);

        // Load 1111 with five writes, then pull reset between edges.
        drv(1, 1, 1, 0, 0, 4'hF, 0, 4'h0);
        repeat (5) step();
        drv(0, 0, 0, 0, 0, 4'h0, 0, 4'h0);
        chk("pre_reset_sr", f_sr, 4'hF);
        chk("pre_reset_cnt", f_cnt, 5);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_sr", f_sr, 4'h0);
        chk("async_reset_cnt", f_cnt, 0);
        chk("async_reset_stl_sr", s_sr, 4'h0);
        chk("async_reset_stl_cnt", s_cnt, 0);
        step();
        rst = 1'b1;

        drv(1, 1, 1, 0, 0, 4'hA, 0, 4'h0);
        step();
        drv(0, 0, 0, 0, 0, 4'h0, 0, 4'h0);
        chk("basic_write_sr", f_sr, 4'hA);
        chk("basic_write_cnt", f_cnt, 1);
        drv(1, 0, 1, 0, 0, 4'h5, 0, 4'h0);
        step();
        chk("no_s_hold", f_sr, 4'hA);

        drv(1, 1, 1, 1, 0, 4'h5, 0, 4'h0);
        step();
        drv(1, 1, 1, 0, 1, 4'h5, 0, 4'h0);
        step();
        drv(1, 1, 0, 0, 0, 4'h5, 0, 4'h0);
        step();
        drv(0, 0, 0, 0, 0, 4'h0, 0, 4'h0);
        chk("blocked_sr", f_sr, 4'hA);
        chk("blocked_cnt", f_cnt, 1);

        // Dependency case, starting from cleared flags.
        rst = 1'b0;
        #1;
        rst = 1'b1;
        drv(1, 1, 1, 0, 0, 4'h8, 1, 4'd0);
        #1;
        chk("fwd_dep_to_cond", f_stc, 4'h8);
        chk("fwd_dep_hazard", f_hz, 0);
        chk("stl_dep_hazard", s_hz, 1);
        chk("stl_dep_to_cond", s_stc, 4'h0);
        id_cond = 4'd14;
        #1;
        chk("fwd_al_to_cond", f_stc, 4'h0);
        chk("stl_al_hazard", s_hz, 0);
        id_cond = 4'd15;
        #1;
        chk("stl_nv_hazard", s_hz, 1);
        id_cond = 4'd0;
        step();
        drv(0, 0, 0, 0, 0, 4'h0, 1, 4'd0);
        #1;
        chk("stl_bubble_hazard", s_hz, 0);
        chk("stl_bubble_to_cond", s_stc, 4'h8);
        chk("fwd_after_to_cond", f_stc, 4'h8);

        last = 4'h0;
        for (int i = 0; i < 20; i++) begin
            last = 4'($urandom_range(0, 15));
            drv(1, 1, 1, 0, 0, last, 0, 4'h0);
            step();
        end
        drv(0, 0, 0, 0, 0, 4'h0, 0, 4'h0);
        chk("sat_cnt", s_cnt, 15);
        chk("sat_last_sr", s_sr, last);
        chk("wide_cnt", f_cnt, 21);

        for (int i = 0; i < 3000; i++) begin
            drv(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
            rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            step();
        end
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 4'h0, 0, 4'h0);
        step();
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
